// File: rtl/seccion_selector.sv
// Section selector for the quadrant painter: debounced next/prev/mode buttons drive a
// wrap-around section index 1..4, with an optional timed auto-rotation mode.
module seccion_selector #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned AUTO_DWELL      = 25000000
) (
  input  logic       clk2,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_mode,
  output logic [2:0] seccion_actual,
  output logic       seccion_cambio,
  output logic       modo_auto
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned DwW = $clog2(AUTO_DWELL);
  localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DwW-1:0] DwMax = DwW'(AUTO_DWELL - 1);

  typedef enum logic [1:0] {StIdle, StManual, StAuto} state_e;

  // Bit 0 = next, bit 1 = prev, bit 2 = mode.
  logic [2:0]     sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]     deb_q, deb_d, deb_dly_q, deb_dly_d;
  logic [DbW-1:0] cnt_q [3];
  logic [DbW-1:0] cnt_d [3];
  logic [2:0]     press;

  state_e         state_q, state_d;
  logic [2:0]     sec_q, sec_d;
  logic [DwW-1:0] dwell_q, dwell_d;
  logic           cambio_q, cambio_d;
  logic           modo_q, modo_d;
  logic           step_next, step_prev;

  function automatic logic [2:0] sec_inc(input logic [2:0] s);
    return (s == 3'd4) ? 3'd1 : s + 3'd1;
  endfunction

  function automatic logic [2:0] sec_dec(input logic [2:0] s);
    return (s == 3'd1) ? 3'd4 : s - 3'd1;
  endfunction

  always_comb begin
    sync1_d   = {btn_mode, btn_prev, btn_next};
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    deb_dly_d = deb_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DbMax) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DbW'(1);
        end
      end
    end
    press = deb_q & ~deb_dly_q;
  end

  always_comb begin
    state_d   = state_q;
    sec_d     = sec_q;
    dwell_d   = dwell_q;
    // Simultaneous next and prev cancel each other.
    step_next = press[0] & ~press[1];
    step_prev = press[1] & ~press[0];
    case (state_q)
      StIdle: begin
        if (press[2]) begin
          state_d = StAuto;
          sec_d   = 3'd1;
          dwell_d = '0;
        end else if (step_next) begin
          state_d = StManual;
          sec_d   = 3'd1;
        end else if (step_prev) begin
          state_d = StManual;
          sec_d   = 3'd4;
        end
      end
      StManual: begin
        if (press[2]) begin
          state_d = StAuto;
          dwell_d = '0;
        end else if (step_next) begin
          sec_d = sec_inc(sec_q);
        end else if (step_prev) begin
          sec_d = sec_dec(sec_q);
        end
      end
      StAuto: begin
        if (press[2]) begin
          state_d = StManual;
        end else if (step_next) begin
          sec_d   = sec_inc(sec_q);
          dwell_d = '0;
        end else if (step_prev) begin
          sec_d   = sec_dec(sec_q);
          dwell_d = '0;
        end else if (dwell_q == DwMax) begin
          sec_d   = sec_inc(sec_q);
          dwell_d = '0;
        end else begin
          dwell_d = dwell_q + DwW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    cambio_d = (sec_d != sec_q);
    modo_d   = (state_d == StAuto);
  end

  always_ff @(posedge clk2) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      state_q   <= StIdle;
      sec_q     <= '0;
      dwell_q   <= '0;
      cambio_q  <= 1'b0;
      modo_q    <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_dly_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      state_q   <= state_d;
      sec_q     <= sec_d;
      dwell_q   <= dwell_d;
      cambio_q  <= cambio_d;
      modo_q    <= modo_d;
    end
  end

  assign seccion_actual = sec_q;
  assign seccion_cambio = cambio_q;
  assign modo_auto      = modo_q;

endmodule
